line_window_conv3x3: RTL and testbench

Depthwise 3×3 convolution stage directly downstream of the 3-line buffer. It accepts one set of three rows (top, middle, bottom), each W pixels × K channels wide, and sweeps the column position. It emits one output column per beat, all K channels in parallel, with zero padding at the left and right edges. After the last column it pulses `conv_done`, which drives the line buffer's `behind_conv_done`.

---
 rtl/conv_pkg.sv | 30 +++
 rtl/window_mac3x3.sv | 41 ++++
 rtl/line_window_conv3x3.sv | 203 ++++++++++++++++++++
 tb/tb_line_window_conv3x3.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the depthwise 3x3 convolution stage:
//   - state_e      : sequencer states (IDLE, RUN, DONE)
//   - acc_bits_f   : signed result width derived from the pixel/weight width
//   - col_bits_f   : column-counter width for a given row length
//   - COL_BITS     : column-counter width for the default row length
// No ports (package).
// ---------------------------------------------------------------------------
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Nine products of (DATA_BITS+1)x(DATA_BITS) bits never exceed 2*DATA_BITS+4 bits.
  function automatic int acc_bits_f(input int data_bits);
    return 2 * data_bits + 4;
  endfunction

  function automatic int col_bits_f(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int DEF_W    = 24;
  localparam int COL_BITS = col_bits_f(DEF_W);

endpackage

// File: rtl/window_mac3x3.sv
// ---------------------------------------------------------------------------
// window_mac3x3
// Combinational 3x3 multiply-accumulate for one channel.
// Ports:
//   pix_i  [9*DATA_BITS] : nine unsigned pixels, tap i at [i*DATA_BITS +: DATA_BITS]
//   wgt_i  [9*DATA_BITS] : nine signed weights, same tap ordering
//   acc_o  [ACC_BITS]    : signed sum of the nine products
// ---------------------------------------------------------------------------
module window_mac3x3
  import conv_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int ACC_BITS  = acc_bits_f(DATA_BITS)
) (
  input  logic [9*DATA_BITS-1:0] pix_i,
  input  logic [9*DATA_BITS-1:0] wgt_i,
  output logic [ACC_BITS-1:0]    acc_o
);

  logic signed [DATA_BITS:0]   px_s;
  logic signed [DATA_BITS:0]   wt_s;
  logic signed [2*DATA_BITS:0] prod_s;
  logic        [ACC_BITS-1:0]  sum_s;

  // Zero-extend pixels, sign-extend weights, and sum the nine signed products.
  always_comb begin
    px_s   = '0;
    wt_s   = '0;
    prod_s = '0;
    sum_s  = '0;
    for (int i = 0; i < 9; i++) begin
      px_s   = {1'b0, pix_i[i*DATA_BITS +: DATA_BITS]};
      wt_s   = {wgt_i[i*DATA_BITS + DATA_BITS - 1], wgt_i[i*DATA_BITS +: DATA_BITS]};
      prod_s = px_s * wt_s;
      sum_s  = sum_s + {{(ACC_BITS-2*DATA_BITS-1){prod_s[2*DATA_BITS]}}, prod_s};
    end
  end

  assign acc_o = sum_s;

endmodule

// File: rtl/line_window_conv3x3.sv
// ---------------------------------------------------------------------------
// line_window_conv3x3
// Depthwise 3x3 convolution over one latched set of three rows. Sweeps the
// column position and emits one column (all K channels) per beat with zero
// padding at both row ends, then pulses conv_done after the last beat.
// Ports:
//   clk, resetn                  : clock (rising edge), async active-low reset
//   row_top/row_mid/row_bot      : W*K pixels each, pixel x chan k at (x*K+k)*DATA_BITS
//   weight_i                     : 9*K weights, tap (r,c) chan k at (k*9+r*3+c)*DATA_BITS
//   valid_i / ready_o            : row-set handshake (ready_o high only in IDLE)
//   out_data / valid_o / last_o  : output beat, chan k at k*ACC_BITS; last_o on column W-1
//   ready_i                      : downstream accepts the beat
//   conv_done                    : one-cycle pulse after the last beat transfers
// Build option: define CONV_RELU_EN to clamp negative channel results to 0.
// ---------------------------------------------------------------------------
module line_window_conv3x3
  import conv_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int W         = DEF_W,
  parameter int K         = 6,
  parameter int ACC_BITS  = acc_bits_f(DATA_BITS)
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [W*K*DATA_BITS-1:0] row_top,
  input  logic [W*K*DATA_BITS-1:0] row_mid,
  input  logic [W*K*DATA_BITS-1:0] row_bot,
  input  logic [9*K*DATA_BITS-1:0] weight_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  output logic [K*ACC_BITS-1:0]    out_data,
  output logic                     valid_o,
  output logic                     last_o,
  input  logic                     ready_i,
  output logic                     conv_done
);

  localparam int CW = col_bits_f(W);
  localparam int RW = W * K * DATA_BITS;
  localparam int WW = 9 * K * DATA_BITS;
  localparam logic [CW-1:0] LAST_COL = CW'(W - 1);

  state_e              state_q, state_d;
  logic [CW-1:0]       col_q, col_d;
  logic [RW-1:0]       row_q [3];
  logic [RW-1:0]       row_d [3];
  logic [WW-1:0]       wgt_q, wgt_d;
  logic [K*ACC_BITS-1:0] out_q, out_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic                done_q, done_d;
  logic                ready_q, ready_d;

  logic [9*DATA_BITS-1:0] win_pix_s [K];
  logic [ACC_BITS-1:0]    mac_s [K];
  logic [K*ACC_BITS-1:0]  res_s;
  int                     x_s;

  // Gather the 3x3 pixel window around col_q per channel; columns -1 and W read as 0.
  always_comb begin
    x_s = 0;
    for (int k = 0; k < K; k++) begin
      win_pix_s[k] = '0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          x_s = int'(col_q) + c - 1;
          if (x_s >= 0 && x_s < W) begin
            win_pix_s[k][(r*3+c)*DATA_BITS +: DATA_BITS] = row_q[r][(x_s*K+k)*DATA_BITS +: DATA_BITS];
          end else begin
            win_pix_s[k][(r*3+c)*DATA_BITS +: DATA_BITS] = '0;
          end
        end
      end
    end
  end

  for (genvar k = 0; k < K; k++) begin : g_mac
    window_mac3x3 #(
      .DATA_BITS (DATA_BITS),
      .ACC_BITS  (ACC_BITS)
    ) u_mac (
      .pix_i (win_pix_s[k]),
      .wgt_i (wgt_q[k*9*DATA_BITS +: 9*DATA_BITS]),
      .acc_o (mac_s[k])
    );
  end

  // Optional ReLU on each channel before the result is registered.
  always_comb begin
    res_s = '0;
    for (int k = 0; k < K; k++) begin
`ifdef CONV_RELU_EN
      if (mac_s[k][ACC_BITS-1]) begin
        res_s[k*ACC_BITS +: ACC_BITS] = '0;
      end else begin
        res_s[k*ACC_BITS +: ACC_BITS] = mac_s[k];
      end
`else
      res_s[k*ACC_BITS +: ACC_BITS] = mac_s[k];
`endif
    end
  end

  // Sequencer next-state: latch on accept, stream columns, release after last transfer.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    for (int r = 0; r < 3; r++) begin
      row_d[r] = row_q[r];
    end
    wgt_d   = wgt_q;
    out_d   = out_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;
    ready_d = ready_q;
    case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          row_d[0] = row_top;
          row_d[1] = row_mid;
          row_d[2] = row_bot;
          wgt_d    = weight_i;
          col_d    = '0;
          state_d  = ST_RUN;
          ready_d  = 1'b0;
        end else begin
          ready_d  = 1'b1;
        end
      end
      ST_RUN: begin
        // Output slot is free when empty or when the held beat is taken this cycle.
        if (!valid_q || ready_i) begin
          out_d   = res_s;
          valid_d = 1'b1;
          last_d  = (col_q == LAST_COL);
          if (col_q == LAST_COL) begin
            col_d   = '0;
            state_d = ST_DONE;
          end else begin
            col_d   = col_q + CW'(1);
          end
        end else begin
          valid_d = valid_q;
        end
      end
      ST_DONE: begin
        if (valid_q && ready_i) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end else begin
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      for (int r = 0; r < 3; r++) begin
        row_q[r] <= '0;
      end
      wgt_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      for (int r = 0; r < 3; r++) begin
        row_q[r] <= row_d[r];
      end
      wgt_q   <= wgt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign out_data  = out_q;
  assign valid_o   = valid_q;
  assign last_o    = last_q;
  assign conv_done = done_q;
  assign ready_o   = ready_q;

endmodule

// File: tb/tb_line_window_conv3x3.sv
// ---------------------------------------------------------------------------
// tb_line_window_conv3x3
// Randomised bench for line_window_conv3x3. A behavioural model computes the
// convolution of each accepted row set directly from pixel/weight arrays and
// queues the expected beats; a monitor on the falling edge checks every
// transfer, stall hold, last_o, ready_o and conv_done timing.
// ---------------------------------------------------------------------------
module tb_line_window_conv3x3;

  localparam int DB  = 8;
  localparam int W   = 24;
  localparam int K   = 6;
  localparam int ACC = 2 * DB + 4;

  logic                 clk;
  logic                 resetn;
  logic [W*K*DB-1:0]    row_top, row_mid, row_bot;
  logic [9*K*DB-1:0]    weight_i;
  logic                 valid_i;
  logic                 ready_o;
  logic [K*ACC-1:0]     out_data;
  logic                 valid_o;
  logic                 last_o;
  logic                 ready_i;
  logic                 conv_done;

  line_window_conv3x3 dut (
    .clk       (clk),
    .resetn    (resetn),
    .row_top   (row_top),
    .row_mid   (row_mid),
    .row_bot   (row_bot),
    .weight_i  (weight_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .out_data  (out_data),
    .valid_o   (valid_o),
    .last_o    (last_o),
    .ready_i   (ready_i),
    .conv_done (conv_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int               scen;
    int               col;
    logic [K*ACC-1:0] data;
  } beat_t;

  beat_t beats[$];

  int pix [3][W][K];
  int wt  [K][9];

  int checks   = 0;
  int errors   = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;
  int rmode    = 0;
  int rcyc     = 0;

  logic             hold_v   = 1'b0;
  logic [K*ACC-1:0] hold_d   = '0;
  logic             pend_last = 1'b0;

  // Pack model arrays into the DUT input vectors.
  task automatic pack_inputs();
    for (int x = 0; x < W; x++)
      for (int k = 0; k < K; k++) begin
        row_top[(x*K+k)*DB +: DB] = DB'(pix[0][x][k]);
        row_mid[(x*K+k)*DB +: DB] = DB'(pix[1][x][k]);
        row_bot[(x*K+k)*DB +: DB] = DB'(pix[2][x][k]);
      end
    for (int k = 0; k < K; k++)
      for (int i = 0; i < 9; i++)
        weight_i[(k*9+i)*DB +: DB] = DB'(wt[k][i]);
  endtask

  function automatic logic [K*ACC-1:0] model_col(input int c);
    logic [K*ACC-1:0] v;
    int acc, x;
    v = '0;
    for (int k = 0; k < K; k++) begin
      acc = 0;
      for (int r = 0; r < 3; r++)
        for (int d = 0; d < 3; d++) begin
          x = c + d - 1;
          if (x >= 0 && x < W) acc += pix[r][x][k] * wt[k][r*3+d];
        end
`ifdef CONV_RELU_EN
      if (acc < 0) acc = 0;
`endif
      v[k*ACC +: ACC] = ACC'(acc);
    end
    return v;
  endfunction

  // Hand-computed values for the fixed scenarios; -99999 means no literal.
  function automatic int lit_val(input int scen, input int c);
    logic edge_col;
    edge_col = (c == 0) || (c == W - 1);
    case (scen)
      1: return edge_col ? 60 : 90;
      2: return c;
`ifdef CONV_RELU_EN
      3: return 0;
`else
      3: return edge_col ? -1530 : -2295;
`endif
      default: return -99999;
    endcase
  endfunction

  function automatic int rnd_w();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  task automatic fill_random();
    for (int r = 0; r < 3; r++)
      for (int x = 0; x < W; x++)
        for (int k = 0; k < K; k++)
          pix[r][x][k] = int'($urandom_range(0, 255));
    for (int k = 0; k < K; k++)
      for (int i = 0; i < 9; i++)
        wt[k][i] = rnd_w();
  endtask

  // ready_i generator: 0 = always 1, 1 = repeating 1,0,0,1, 2 = random.
  always @(posedge clk) begin
    #1;
    rcyc++;
    case (rmode)
      1:       ready_i = ((rcyc % 4) == 0) || ((rcyc % 4) == 3);
      2:       ready_i = 1'($urandom_range(0, 1));
      default: ready_i = 1'b1;
    endcase
  end

  // Monitor: checks every cycle on the falling edge, when inputs and outputs are stable.
  always @(negedge clk) begin
    beat_t b;
    int lv;
    logic [K*ACC-1:0] lvec;
    if (!resetn) begin
      hold_v    = 1'b0;
      pend_last = 1'b0;
    end else begin
      checks++;
      if (conv_done !== pend_last) begin
        errors++;
        $display("FAIL conv_done_timing: got %b want %b at %0t", conv_done, pend_last, $time);
      end
      if (conv_done === 1'b1) begin
        done_cnt++;
        checks++;
        if (ready_o !== 1'b1) begin
          errors++;
          $display("FAIL ready_with_done: ready_o=%b want 1", ready_o);
        end
      end
      if (valid_o === 1'b1) begin
        checks++;
        if (ready_o !== 1'b0) begin
          errors++;
          $display("FAIL ready_while_busy: ready_o=%b want 0", ready_o);
        end
      end
      if (hold_v) begin
        checks++;
        if (valid_o !== 1'b1 || out_data !== hold_d) begin
          errors++;
          $display("FAIL stall_hold: valid=%b data=%h want valid=1 data=%h", valid_o, out_data, hold_d);
        end
      end
      pend_last = 1'b0;
      hold_v    = 1'b0;
      if (valid_o === 1'b1 && ready_i === 1'b1) begin
        xfer_cnt++;
        checks++;
        if (beats.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: data=%h", out_data);
        end else begin
          b = beats.pop_front();
          if (out_data !== b.data) begin
            errors++;
            $display("FAIL beat_data col %0d: got %h want %h", b.col, out_data, b.data);
          end
          checks++;
          if (last_o !== (b.col == W - 1)) begin
            errors++;
            $display("FAIL last_o col %0d: got %b want %b", b.col, last_o, (b.col == W - 1));
          end
          lv = lit_val(b.scen, b.col);
          if (lv != -99999) begin
            lvec = '0;
            for (int k = 0; k < K; k++) lvec[k*ACC +: ACC] = ACC'(lv);
            checks++;
            if (out_data !== lvec) begin
              errors++;
              $display("FAIL literal scen %0d col %0d: got %h want %h", b.scen, b.col, out_data, lvec);
            end
          end
          pend_last = (b.col == W - 1);
        end
      end else if (valid_o === 1'b1) begin
        hold_v = 1'b1;
        hold_d = out_data;
      end
    end
  end

  task automatic check_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  // Wait for ready_o, present the row set for one cycle and queue expected beats.
  task automatic accept_job(input int scen);
    int n;
    n = 0;
    while (ready_o !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout: ready_o=%b want 1", ready_o);
    end
    pack_inputs();
    for (int c = 0; c < W; c++) beats.push_back('{scen, c, model_col(c)});
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    check_bit("ready_after_accept", ready_o, 1'b0);
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 400) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (done_cnt < target) begin
      errors++;
      $display("FAIL done_timeout: done_cnt=%0d want %0d", done_cnt, target);
    end
  endtask

  task automatic wait_xfers(input int target);
    int n;
    n = 0;
    while (xfer_cnt < target && n < 400) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (xfer_cnt < target) begin
      errors++;
      $display("FAIL xfer_timeout: xfer_cnt=%0d want %0d", xfer_cnt, target);
    end
  endtask

  initial begin
    int base;
    resetn   = 1'b0;
    valid_i  = 1'b0;
    ready_i  = 1'b1;
    row_top  = '0;
    row_mid  = '0;
    row_bot  = '0;
    weight_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check_bit("rst_valid_o", valid_o, 1'b0);
    check_bit("rst_last_o", last_o, 1'b0);
    check_bit("rst_conv_done", conv_done, 1'b0);
    check_bit("rst_ready_o", ready_o, 1'b1);
    check_bit("rst_out_zero", (out_data == '0), 1'b1);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Scenario 1: flat rows of 10, all weights +1, full throughput, 1-cycle latency.
    rmode = 0;
    for (int r = 0; r < 3; r++) for (int x = 0; x < W; x++) for (int k = 0; k < K; k++) pix[r][x][k] = 10;
    for (int k = 0; k < K; k++) for (int i = 0; i < 9; i++) wt[k][i] = 1;
    accept_job(1);
    check_bit("first_beat_not_yet", valid_o, 1'b0);
    @(posedge clk); #1;
    check_bit("first_beat_latency", valid_o, 1'b1);
    wait_done(1);
    check_bit("xfers_job1", (xfer_cnt == W), 1'b1);

    // Scenario 2: mid row pixel x = x, only centre weight = 1.
    for (int x = 0; x < W; x++)
      for (int k = 0; k < K; k++) begin
        pix[0][x][k] = int'($urandom_range(0, 255));
        pix[1][x][k] = x;
        pix[2][x][k] = int'($urandom_range(0, 255));
      end
    for (int k = 0; k < K; k++) for (int i = 0; i < 9; i++) wt[k][i] = (i == 4) ? 1 : 0;
    accept_job(2);
    wait_done(2);

    // Scenario 3: saturated pixels, all weights -1, random backpressure.
    rmode = 2;
    for (int r = 0; r < 3; r++) for (int x = 0; x < W; x++) for (int k = 0; k < K; k++) pix[r][x][k] = 255;
    for (int k = 0; k < K; k++) for (int i = 0; i < 9; i++) wt[k][i] = -1;
    accept_job(3);
    wait_done(3);

    // Scenario 4: random data with 1,0,0,1 backpressure.
    rmode = 1;
    fill_random();
    accept_job(4);
    wait_done(4);

    // Scenario 5: valid_i with different data mid-run must be ignored.
    rmode = 0;
    fill_random();
    base = xfer_cnt;
    accept_job(5);
    wait_xfers(base + 10);
    fill_random();
    pack_inputs();
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    wait_done(5);
    check_bit("xfers_after_ignored_valid", (xfer_cnt == base + W), 1'b1);

    // Scenario 6: reset mid-run, then a full job after release.
    fill_random();
    base = xfer_cnt;
    accept_job(6);
    wait_xfers(base + 10);
    #2;
    resetn = 1'b0;
    #1;
    check_bit("midrst_valid_o", valid_o, 1'b0);
    check_bit("midrst_ready_o", ready_o, 1'b1);
    check_bit("midrst_conv_done", conv_done, 1'b0);
    check_bit("midrst_last_o", last_o, 1'b0);
    beats.delete();
    repeat (2) @(posedge clk);
    #1;
    check_bit("midrst_no_done", conv_done, 1'b0);
    resetn = 1'b1;
    @(posedge clk); #1;
    check_bit("done_cnt_unchanged", (done_cnt == 5), 1'b1);
    fill_random();
    base = xfer_cnt;
    accept_job(7);
    wait_done(6);
    check_bit("xfers_after_reset", (xfer_cnt == base + W), 1'b1);

    // Scenario 7: a few random jobs with random backpressure.
    rmode = 2;
    for (int j = 0; j < 4; j++) begin
      fill_random();
      accept_job(8);
      wait_done(7 + j);
    end
    repeat (4) @(posedge clk);
    #1;
    check_bit("queue_drained", (beats.size() == 0), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
